// File: rtl/ram_fifo_pkg.sv
// Shared constants for the RAM-backed FIFO controller.
// Word width, RAM geometry and fill-level width.
package ram_fifo_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;
  localparam int LVL_W  = ADDR_W + 2;

endpackage

// File: rtl/ram_fifo_obuf.sv
// Two-entry output buffer in front of the consumer.
// Absorbs the RAM read latency so the stream runs at one word per cycle.
module ram_fifo_obuf
  import ram_fifo_pkg::*;
#(
  parameter int WIDTH = ram_fifo_pkg::DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             capture,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic [1:0]       cnt
);

  logic [WIDTH-1:0] tail;

  assign valid = (cnt != 2'd0);

  // Head/tail shuffle; a capture racing a pop of the last word lands in head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= 2'd0;
    end else begin
      cnt <= cnt + {1'b0, capture} - {1'b0, pop};
      priority case (1'b1)
        pop && (cnt == 2'd2): begin
          head <= tail;
          if (capture) tail <= din;
        end
        pop: begin
          if (capture) head <= din;
        end
        capture && (cnt == 2'd0): head <= din;
        capture: tail <= din;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving a dual-port RAM: port 1 pushes, port 2 prefetches.
// Tracks pointers, RAM occupancy and the one-cycle registered read.
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int DATA_W = ram_fifo_pkg::DATA_W,
  parameter int ADDR_W = ram_fifo_pkg::ADDR_W,
  parameter int DEPTH  = ram_fifo_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W+1:0] level,
  output logic [DATA_W-1:0] ram_data_p1,
  output logic [ADDR_W-1:0] ram_addr_p1,
  output logic              ram_wr_p1,
  output logic [ADDR_W-1:0] ram_addr_p2,
  output logic              ram_wr_p2,
  input  logic [DATA_W-1:0] ram_out_p2
);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   ram_cnt;
  logic              inflight;
  logic [1:0]        ob_cnt;
  logic              push;
  logic              pop;
  logic              fetch;
  logic [ADDR_W:0]   ram_cnt_nx;
  logic [1:0]        ob_cnt_nx;
  logic [ADDR_W+1:0] level_nx;

  assign s_ready = (ram_cnt < (ADDR_W+1)'(DEPTH));
  assign push    = s_valid & s_ready;
  assign pop     = m_valid & m_ready;

  // Fetch only while the buffer plus the pending read leaves room after pop.
  assign fetch = (ram_cnt != '0) &&
    (({1'b0, ob_cnt} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));

  assign ram_cnt_nx = ram_cnt
    + {{ADDR_W{1'b0}}, push}
    - {{ADDR_W{1'b0}}, fetch};
  assign ob_cnt_nx = ob_cnt + {1'b0, inflight} - {1'b0, pop};
  assign level_nx  = {1'b0, ram_cnt_nx}
    + {{(ADDR_W+1){1'b0}}, fetch}
    + {{ADDR_W{1'b0}}, ob_cnt_nx};

  assign ram_data_p1 = s_data;
  assign ram_addr_p1 = wr_ptr;
  assign ram_wr_p1   = push & rst_n;
  assign ram_addr_p2 = rd_ptr;
  assign ram_wr_p2   = 1'b0;

  // Pointer, occupancy, read-pending and fill-level state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ram_cnt  <= '0;
      inflight <= 1'b0;
      level    <= '0;
    end else begin
      wr_ptr   <= wr_ptr + ADDR_W'(push);
      rd_ptr   <= rd_ptr + ADDR_W'(fetch);
      ram_cnt  <= ram_cnt_nx;
      inflight <= fetch;
      level    <= level_nx;
    end
  end

  ram_fifo_obuf #(
    .WIDTH(DATA_W)
  ) u_obuf (
    .clk    (clk),
    .rst_n  (rst_n),
    .capture(inflight),
    .din    (ram_out_p2),
    .pop    (pop),
    .head   (m_data),
    .valid  (m_valid),
    .cnt    (ob_cnt)
  );

endmodule
